// File: rtl/key_filter_pkg.sv
// Shared types and defaults for the multi-key debounce / event generator.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } key_fsm_t;

  localparam int unsigned DEB_CYC_DEF    = 1_000_000;
  localparam int unsigned LONG_CYC_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYC_DEF = 10_000_000;

  // Counter width for a cycle-count parameter, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold/repeat counters and
// registered level/pulse outputs.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int unsigned DEB_CYC    = DEB_CYC_DEF,
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = cnt_width(DEB_CYC);
  localparam int unsigned HW = cnt_width(LONG_CYC);
  localparam int unsigned RW = cnt_width(REPEAT_CYC);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 32'd1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 32'd1);
  localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYC == 32'd0) ? 32'd0 : REPEAT_CYC - 32'd1);
  localparam logic          REP_EN    = (REPEAT_CYC != 32'd0);

  logic [1:0]    sync_q;
  key_fsm_t      fsm_q, fsm_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          long_done_q, long_done_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          count_hold;
  logic          s;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q      <= 2'b11;
      fsm_q       <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      long_done_q <= 1'b0;
      state_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_i};
      fsm_q       <= fsm_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      long_done_q <= long_done_d;
      state_q     <= state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    long_done_d = long_done_q;
    state_d     = state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    count_hold  = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (!s) begin
          fsm_d = PRESS_DEB;
          deb_d = '0;
        end
      end
      PRESS_DEB: begin
        if (s) begin
          fsm_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          fsm_d       = HELD;
          press_d     = 1'b1;
          state_d     = 1'b1;
          hold_d      = '0;
          rep_d       = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      HELD: begin
        if (s) begin
          fsm_d = REL_DEB;
          deb_d = '0;
        end else begin
          count_hold = 1'b1;
        end
      end
      REL_DEB: begin
        // A low sample ends the excursion and counts as a held cycle again.
        if (!s) begin
          fsm_d      = HELD;
          count_hold = 1'b1;
        end else if (deb_q == DEB_LAST) begin
          fsm_d     = IDLE;
          release_d = 1'b1;
          state_d   = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase

    // hold_q saturates at LONG_LAST; the repeat counter takes over afterwards.
    if (count_hold) begin
      if (!long_done_q) begin
        if (hold_q == LONG_LAST) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
          rep_d       = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end else if (REP_EN) begin
        if (rep_q == REP_LAST) begin
          repeat_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_filter.sv
// Multi-key debounce and event generator: KEY_W independent channels.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned DEB_CYC    = DEB_CYC_DEF,
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  for (genvar g = 0; g < KEY_W; g++) begin : g_ch
    key_filter_ch #(
      .DEB_CYC   (DEB_CYC),
      .LONG_CYC  (LONG_CYC),
      .REPEAT_CYC(REPEAT_CYC)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .key_i    (key[g]),
      .state_o  (key_state[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g]),
      .repeat_o (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: stimulus queues expected pulse events,
// a forked monitor pops and compares whenever any pulse output is high.
module tb_key_filter;

  localparam int unsigned KW = 4;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] rp;
  } ev_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [KW-1:0] key;
  logic [KW-1:0] key_state, key_press, key_release, key_long, key_repeat;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];

  key_filter #(
    .KEY_W(KW), .DEB_CYC(8), .LONG_CYC(32), .REPEAT_CYC(16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [3:0] p, input logic [3:0] r,
                               input logic [3:0] l, input logic [3:0] rp);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.l = l; e.rp = rp;
    exp_q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  initial begin
    int e, p, r;
    rstn = 1'b0;
    key  = '1;

    // Monitor: every cycle with a pulse consumes one scoreboard entry.
    fork
      forever begin
        ev_t ev;
        @(negedge clk);
        if ((key_press | key_release | key_long | key_repeat) != '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b long=%b rep=%b",
                     cyc, key_press, key_release, key_long, key_repeat);
          end else begin
            ev = exp_q.pop_front();
            if (ev.cyc != cyc || ev.p !== key_press || ev.r !== key_release ||
                ev.l !== key_long || ev.rp !== key_repeat) begin
              errors++;
              $display("FAIL event got cyc=%0d p=%b r=%b l=%b rp=%b expected cyc=%0d p=%b r=%b l=%b rp=%b",
                       cyc, key_press, key_release, key_long, key_repeat,
                       ev.cyc, ev.p, ev.r, ev.l, ev.rp);
            end
          end
        end
      end
    join_none

    step(3);
    chk("reset_outputs", {key_state, key_press, key_release, key_long, key_repeat}, 20'h0);
    rstn = 1'b1;
    step(3);

    // Clean press / release on key 0
    e = cyc;
    key[0] = 1'b0;
    push(e + 11, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(e + 31, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_to(e + 10); chk("clean_state_pre", 20'(key_state), 20'h0);
    wait_to(e + 11); chk("clean_state_press", 20'(key_state), 20'h1);
    wait_to(e + 19); chk("clean_state_hold", 20'(key_state), 20'h1);
    wait_to(e + 20); key[0] = 1'b1;
    wait_to(e + 30); chk("clean_state_reldeb", 20'(key_state), 20'h1);
    wait_to(e + 31); chk("clean_state_rel", 20'(key_state), 20'h0);
    step(10);

    // Bounce on key 1: 3 low / 3 high, never stable for 8 cycles
    for (int i = 0; i < 40; i++) begin
      key[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
      if (i % 4 == 3) chk("bounce_state", 20'(key_state), 20'h0);
    end
    key[1] = 1'b1;
    step(20);
    chk("bounce_state_end", 20'(key_state), 20'h0);

    // Long press and repeat on key 2
    e = cyc;
    key[2] = 1'b0;
    push(e + 11, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push(e + 43, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push(e + 59, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push(e + 75, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push(e + 91, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push(e + 111, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    wait_to(e + 100); key[2] = 1'b1;
    wait_to(e + 110); chk("long_state_reldeb", 20'(key_state), 20'h4);
    wait_to(e + 111); chk("long_state_rel", 20'(key_state), 20'h0);
    step(10);

    // Release glitch on key 3 at hold count 10: long slips by 4 cycles
    e = cyc;
    p = e + 11;
    key[3] = 1'b0;
    push(p, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push(p + 36, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    push(p + 47, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    wait_to(p + 10); key[3] = 1'b1;
    wait_to(p + 14); key[3] = 1'b0;
    wait_to(p + 16); chk("glitch_state_mid", 20'(key_state), 20'h8);
    wait_to(p + 20); chk("glitch_state_after", 20'(key_state), 20'h8);
    wait_to(p + 36); key[3] = 1'b1;
    wait_to(p + 46); chk("glitch_state_reldeb", 20'(key_state), 20'h8);
    wait_to(p + 47); chk("glitch_state_rel", 20'(key_state), 20'h0);
    step(10);

    // All keys together
    e = cyc;
    key = 4'b0000;
    push(e + 11, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    push(e + 31, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    wait_to(e + 11); chk("simul_state_press", 20'(key_state), 20'hF);
    wait_to(e + 20); key = 4'b1111;
    wait_to(e + 31); chk("simul_state_rel", 20'(key_state), 20'h0);
    step(10);

    // Reset during key 0 debounce while key 1 is held
    e = cyc;
    key[1] = 1'b0;
    push(e + 11, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    wait_to(e + 12); key[0] = 1'b0;
    wait_to(e + 17); chk("rst_state_before", 20'(key_state), 20'h2);
    rstn = 1'b0;
    #1;
    chk("rst_async_outputs", {key_state, key_press, key_release, key_long, key_repeat}, 20'h0);
    step(2);
    r = cyc;
    rstn = 1'b1;
    push(r + 11, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    push(r + 23, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
    wait_to(r + 10); chk("rst_state_pre", 20'(key_state), 20'h0);
    wait_to(r + 11); chk("rst_state_press", 20'(key_state), 20'h3);
    wait_to(r + 12); key = 4'b1111;
    wait_to(r + 23); chk("rst_state_rel", 20'(key_state), 20'h0);

    // Drain: anything left in the scoreboard never appeared
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    while (exp_q.size() != 0) begin
      ev_t m;
      m = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event expected cyc=%0d p=%b r=%b l=%b rp=%b got none",
               m.cyc, m.p, m.r, m.l, m.rp);
    end
    step(5);
    chk("final_state", 20'(key_state), 20'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
